seq_detect_ctrl: RTL

Programmable serial pattern-detector controller for the sequence-detector datapath. It latches a pattern of 1–MAX_LEN bits with an overlap/non-overlap mode and a match target, then arms on `start`. While armed it scans a qualified serial bit stream and counts matches. It stops on reaching the target or on `stop`, and reports completion to the sequencing logic above it.

---
 rtl/seq_ctrl_pkg.sv | 18 +
 rtl/seq_match_core.sv | 60 ++++++
 rtl/seq_detect_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-detector controller:
// state encoding, default sizes and the legal-length check.
package seq_ctrl_pkg;

   localparam int unsigned DEF_MAX_LEN = 8;
   localparam int unsigned DEF_CNT_W   = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked compare; raises a
// combinational hit when the newest len bits equal the pattern.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_en,
   input  logic               i_x_valid,
   input  logic               i_x,
   input  logic [MAX_LEN-1:0] i_pattern,
   input  logic [LEN_W-1:0]   i_len,
   input  logic               i_overlap,
   output logic               o_hit
);

   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN:0]   w_cat;
   logic [MAX_LEN-1:0] w_shift;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_enough;

   assign w_cat    = {r_hist, i_x};
   assign w_shift  = w_cat[MAX_LEN-1:0];
   assign w_enough = ((LEN_W + 1)'(r_fill) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(i_len);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i_len > LEN_W'(i));
      end
   end

   assign o_hit = i_en && i_x_valid && w_enough &&
                  ((w_shift & w_mask) == (i_pattern & w_mask));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_en && i_x_valid) begin
         r_hist <= w_shift;
         // Non-overlap mode demands len fresh bits before the next match.
         if (o_hit && !i_overlap) begin
            r_fill <= '0;
         end else if (r_fill != LEN_W'(MAX_LEN)) begin
            r_fill <= r_fill + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detector controller: config registers,
// IDLE/RUN/DONE FSM, saturating match counter and registered outputs.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_cfg_we,
   input  logic [MAX_LEN-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic               i_cfg_overlap,
   input  logic [CNT_W-1:0]   i_cfg_target,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_x_valid,
   input  logic               i_x,
   output logic               o_busy,
   output logic               o_match,
   output logic [CNT_W-1:0]   o_match_cnt,
   output logic               o_done,
   output logic               o_cfg_err
);

   state_t             r_state,   w_state_nxt;
   logic [MAX_LEN-1:0] r_pattern, w_pattern_nxt;
   logic [LEN_W-1:0]   r_len,     w_len_nxt;
   logic               r_overlap, w_overlap_nxt;
   logic [CNT_W-1:0]   r_target,  w_target_nxt;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
   logic               r_match,   w_match_nxt;
   logic               r_err,     w_err_nxt;
   logic               w_clear;
   logic               w_hit;
   logic               w_we_ok;

   assign w_we_ok = i_cfg_we && len_legal(32'(i_cfg_len), MAX_LEN);

   seq_match_core #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_core (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_clear),
      .i_en      (r_state == StRun),
      .i_x_valid (i_x_valid),
      .i_x       (i_x),
      .i_pattern (r_pattern),
      .i_len     (r_len),
      .i_overlap (r_overlap),
      .o_hit     (w_hit)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_pattern_nxt = r_pattern;
      w_len_nxt     = r_len;
      w_overlap_nxt = r_overlap;
      w_target_nxt  = r_target;
      w_cnt_nxt     = r_cnt;
      w_match_nxt   = 1'b0;
      w_err_nxt     = 1'b0;
      w_clear       = 1'b0;
      unique case (r_state)
         StIdle: begin
            // An illegal write also kills a same-cycle start: one error pulse.
            if (i_cfg_we && !w_we_ok) begin
               w_err_nxt = 1'b1;
            end else begin
               if (w_we_ok) begin
                  w_pattern_nxt = i_cfg_pattern;
                  w_len_nxt     = i_cfg_len;
                  w_overlap_nxt = i_cfg_overlap;
                  w_target_nxt  = i_cfg_target;
               end
               if (i_start) begin
                  if (len_legal(32'(w_len_nxt), MAX_LEN)) begin
                     w_state_nxt = StRun;
                     w_cnt_nxt   = '0;
                     w_clear     = 1'b1;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
         end
         StRun: begin
            w_err_nxt = i_cfg_we;
            if (w_hit) begin
               w_match_nxt = 1'b1;
               if (r_cnt != '1) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            if ((w_hit && (r_target != '0) && (w_cnt_nxt == r_target)) || i_stop) begin
               w_state_nxt = StDone;
            end
         end
         StDone: w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= StIdle;
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_target  <= '0;
         r_cnt     <= '0;
         r_match   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pattern <= w_pattern_nxt;
         r_len     <= w_len_nxt;
         r_overlap <= w_overlap_nxt;
         r_target  <= w_target_nxt;
         r_cnt     <= w_cnt_nxt;
         r_match   <= w_match_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign o_busy      = (r_state == StRun);
   assign o_done      = (r_state == StDone);
   assign o_match     = r_match;
   assign o_match_cnt = r_cnt;
   assign o_cfg_err   = r_err;

endmodule
